stall_control_unit: RTL
=======================

Name: stall_control_unit

Overview:
- Consumer end of the hazard interface in the 5-stage pipeline: takes hazard_detected plus EXE-stage branch resolution and the MEM-stage SRAM handshake.
- Drives the freeze, flush and bubble controls for PC, IF/ID, ID/EXE and the back-end pipeline registers.
- Tracks stall and flush events with saturating performance counters and a sticky watchdog for runaway stalls.

Parameters:
CNT_W, 16, width of stall_cycles and flush_count
MAX_HAZ_STALL, 3, max consecutive hazard-stall cycles before watchdog_err sets
MEM_TIMEOUT, 64, max consecutive memory-wait cycles before watchdog_err sets

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
hazard_detected  in  1  RAW hazard flag from the hazard detection unit
Branch_taken  in  1  branch resolved taken in EXE this cycle
mem_req  in  1  MEM stage holds a load/store this cycle
mem_ready  in  1  SRAM completes the MEM-stage access this cycle
freeze_pc  out  1  hold PC
freeze_if_id  out  1  hold IF/ID register
flush_if_id  out  1  zero IF/ID register on next edge
bubble_id_exe  out  1  zero ID/EXE control bits (WB_EN, MEM_R/W, B, S) on next edge
freeze_pipe  out  1  hold ID/EXE, EXE/MEM, MEM/WB registers
stall_cycles  out  CNT_W  count of cycles with freeze_pc=1
flush_count  out  CNT_W  count of branch flushes
watchdog_err  out  1  sticky stall-timeout error

Behaviour:
- Reset: state=RUN; counters=0; watchdog_err=0; hazard and memory-wait run counters=0. All control outputs are forced to 0 while rst=1, independent of the inputs.
- Control outputs are combinational from the current state and inputs (0-cycle latency), so a stall applies in the cycle the hazard is flagged. Counters and state update on the rising clk edge.
- Priority: memory wait > branch flush > hazard stall.
- mem_wait = mem_req & !mem_ready.
  - When mem_wait=1: freeze_pc = freeze_if_id = freeze_pipe = 1; flush_if_id = bubble_id_exe = 0.
  - Branch_taken and hazard_detected are ignored while mem_wait=1. The EXE stage is frozen, so it re-presents the branch after the wait.
- Else if Branch_taken: flush_if_id = bubble_id_exe = 1; all freezes = 0, so the PC loads the branch target. hazard_detected is ignored in this cycle.
- Else if hazard_detected: freeze_pc = freeze_if_id = bubble_id_exe = 1; freeze_pipe = flush_if_id = 0.
- Else: all control outputs 0.
- FSM states RUN, HAZ_STALL, MEM_WAIT. Next state is evaluated every edge:
  - mem_wait → MEM_WAIT
  - else !Branch_taken & hazard_detected → HAZ_STALL
  - else → RUN
  - So MEM_WAIT→RUN occurs on the edge where mem_ready=1, and the pipeline advances on that same edge.
- Hazard run counter:
  - increments on each edge where hazard stall is active, i.e. hazard_detected & !Branch_taken & !mem_wait
  - holds while mem_wait=1
  - clears otherwise
  - If it reaches MAX_HAZ_STALL with the hazard still asserted, watchdog_err sets on that edge.
- Memory-wait counter:
  - increments on each mem_wait edge, clears otherwise
  - If it reaches MEM_TIMEOUT with mem_wait still 1, watchdog_err sets.
  - The freeze is held regardless of the watchdog; the block never self-releases.
- watchdog_err clears only on rst.
- stall_cycles: +1 on every edge with freeze_pc=1.
- flush_count: +1 on every edge with flush_if_id=1.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous mem_ready and a new hazard: the memory freeze drops that cycle; the hazard stall applies in the same cycle; next state is HAZ_STALL.
- rst asserted mid-stall: outputs drop to 0 immediately; state and counters clear asynchronously.

Test Plan:
- Reset: assert rst with hazard_detected=1, mem_req=1 → all outputs 0, stall_cycles=0, flush_count=0; after release with idle inputs, outputs stay 0.
- Hazard: hazard_detected=1 for 2 cycles → freeze_pc=freeze_if_id=bubble_id_exe=1 in both cycles, freeze_pipe=0, stall_cycles=2, watchdog_err=0.
- Branch vs hazard: Branch_taken=1 and hazard_detected=1 in the same cycle → flush_if_id=bubble_id_exe=1, freeze_pc=0, flush_count=1, stall_cycles unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles then mem_ready=1, with Branch_taken=1 throughout → freeze_pipe=1 for 5 cycles, flush_if_id=0 during the wait, flush_if_id=1 on the ready cycle, stall_cycles=5, flush_count=1.
- Watchdog:
  - hazard_detected held for 4 cycles with MAX_HAZ_STALL=3 → watchdog_err=1 after the 3rd edge, remains 1 after the hazard drops, clears only on rst.
  - mem_wait held for 64 edges with MEM_TIMEOUT=64 → watchdog_err=1.
- Saturation: CNT_W=4, hold hazard_detected for 20 cycles → stall_cycles stops at 15.

Source files
------------

// File: rtl/stall_control_unit.sv
// stall_control_unit: pipeline freeze/flush/bubble control with saturating stall/flush counters
// and a sticky watchdog for runaway hazard or memory stalls.
module stall_control_unit #(
  parameter int CNT_W         = 16,
  parameter int MAX_HAZ_STALL = 3,
  parameter int MEM_TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             Branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_pipe,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             watchdog_err
);
  localparam int HW = $clog2(MAX_HAZ_STALL + 1);
  localparam int MW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, HAZ_STALL, MEM_WAIT} state_t;
  state_t state_q, state_d;
  logic mem_wait, haz_stall, flush;
  logic [HW-1:0] haz_q, haz_d;
  logic [MW-1:0] mem_q, mem_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic wd_q, wd_d;
  always_comb begin
    mem_wait      = mem_req & ~mem_ready;
    flush         = ~mem_wait & Branch_taken;
    haz_stall     = ~mem_wait & ~Branch_taken & hazard_detected;
    state_d       = mem_wait ? MEM_WAIT : haz_stall ? HAZ_STALL : RUN;
    freeze_pc     = ~rst & (mem_wait | haz_stall);
    freeze_if_id  = freeze_pc;
    freeze_pipe   = ~rst & mem_wait;
    flush_if_id   = ~rst & flush;
    bubble_id_exe = ~rst & (flush | haz_stall);
    // hazard run survives a memory wait so a stall split by the wait still trips the watchdog
    haz_d   = haz_stall ? (haz_q == HW'(MAX_HAZ_STALL) ? haz_q : haz_q + HW'(1)) :
              mem_wait  ? haz_q : '0;
    mem_d   = !mem_wait ? '0 : state_q != MEM_WAIT ? MW'(1) :
              mem_q == MW'(MEM_TIMEOUT) ? mem_q : mem_q + MW'(1);
    wd_d    = wd_q | (haz_stall & (haz_d >= HW'(MAX_HAZ_STALL))) |
              (mem_wait & (mem_d >= MW'(MEM_TIMEOUT)));
    stall_d = (freeze_pc && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (flush_if_id && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      haz_q   <= '0;
      mem_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      haz_q   <= haz_d;
      mem_q   <= mem_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      wd_q    <= wd_d;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign watchdog_err = wd_q;
endmodule
